// File: rtl/host_reg_responder_pkg.sv
// ---------------------------------------------------------------------------
// host_reg_pkg
// Shared definitions for the host-pin register responder: default bus
// widths, the special register addresses and the handshake FSM state type.
// No ports; imported by host_reg_responder and sync_ff.
// ---------------------------------------------------------------------------
package host_reg_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 4;
  localparam int RO_ADDR_DEF = 15;

  // Register 0 feeds the core; writing it with bit 7 set clears the
  // read-only write error flag.
  localparam int CTRL_ADDR   = 0;
  localparam int ERR_CLR_BIT = 7;

  typedef enum logic [1:0] {
    ST_WAIT_REL = 2'd0,
    ST_IDLE     = 2'd1,
    ST_EXEC     = 2'd2,
    ST_ACK      = 2'd3
  } state_t;

endpackage

// File: rtl/host_reg_responder_sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// N-stage level synchroniser for asynchronous input pins, with synchronous
// active-high reset that clears every stage.
// Ports:
//   clk  - sampling clock
//   rst  - synchronous active-high reset
//   i_d  - asynchronous input level(s)
//   o_q  - synchronised output, STAGES clock edges behind i_d
// ---------------------------------------------------------------------------
module sync_ff
  import host_reg_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  // Plain shift chain; stage 0 is the only flop that sees the raw pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/host_reg_responder.sv
// ---------------------------------------------------------------------------
// host_reg_responder
// Responder side of the 4-phase req/ack host register handshake. The request
// level is synchronised, then one write or read is executed against a bank
// of 2^ADDR_W registers and acknowledged until the host drops req.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   req_i       - asynchronous host request level
//   we_i        - 1 = write, 0 = read (stable while req_i high)
//   addr_i      - register address (stable while req_i high)
//   wdata_i     - write data (stable while req_i high)
//   ack_o       - registered acknowledge
//   rdata_o     - read data, valid while ack_o high on a read
//   busy_o      - FSM not in IDLE
//   ctrl_o      - live copy of register 0
//   status_i    - core status, returned when reading RO_ADDR
//   wr_pulse_o  - one-cycle pulse per accepted write
//   ro_err_o    - sticky flag, set by a write to RO_ADDR
// ---------------------------------------------------------------------------
module host_reg_responder
  import host_reg_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int RO_ADDR     = RO_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] ctrl_o,
  input  logic [DATA_W-1:0] status_i,
  output logic              wr_pulse_o,
  output logic              ro_err_o
);

  localparam int                NUM_REGS  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] RO_A      = ADDR_W'(RO_ADDR);
  localparam logic [ADDR_W-1:0] CTRL_A    = ADDR_W'(CTRL_ADDR);
  localparam int                CNT_W     = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  FILL_DONE = CNT_W'(SYNC_STAGES);

  logic              w_reqS;
  state_t            r_state;
  state_t            w_nextState;
  logic              w_capture;
  logic              w_exec;
  logic              w_doWrite;
  logic              w_roWrite;
  logic              w_doRead;
  logic              w_filled;
  logic [CNT_W-1:0]  r_fillCnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_bank [NUM_REGS];
  logic              r_ack;
  logic [DATA_W-1:0] r_rdata;
  logic              r_wrPulse;
  logic              r_roErr;

  sync_ff #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1)
  ) u_reqSync (
    .clk (clk),
    .rst (rst),
    .i_d (req_i),
    .o_q (w_reqS)
  );

  // The synchroniser is cleared by reset, so right after reset req_s reads 0
  // even if the host is still holding req. WAIT_REL therefore ignores req_s
  // until the chain has refilled from the pin; otherwise a held request
  // would be replayed as soon as reset lifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fillCnt <= '0;
    end else if (r_fillCnt != FILL_DONE) begin
      r_fillCnt <= r_fillCnt + CNT_W'(1);
    end
  end

  assign w_filled = (r_fillCnt == FILL_DONE);

  // Handshake state register. ack is registered from the next state so it
  // rises on the EXEC->ACK edge and falls on the ACK->IDLE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_WAIT_REL;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_ack   <= (w_nextState == ST_ACK);
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    w_exec      = 1'b0;
    case (r_state)
      ST_WAIT_REL: begin
        if (w_filled && !w_reqS) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (w_reqS) begin
          w_nextState = ST_EXEC;
          w_capture   = 1'b1;
        end
      end
      ST_EXEC: begin
        w_nextState = ST_ACK;
        w_exec      = 1'b1;
      end
      ST_ACK: begin
        if (!w_reqS) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_WAIT_REL;
      end
    endcase
  end

  assign w_doWrite = w_exec &&  r_we && (r_addr != RO_A);
  assign w_roWrite = w_exec &&  r_we && (r_addr == RO_A);
  assign w_doRead  = w_exec && !r_we;

  // Host-side fields are unsynchronised; they are only trusted once req_s
  // has been seen, because the host keeps them stable while req is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_capture) begin
      r_we    <= we_i;
      r_addr  <= addr_i;
      r_wdata <= wdata_i;
    end
  end

  // Register bank. The RO_ADDR slot is never written; reads there are
  // redirected to status_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_bank[i] <= '0;
      end
    end else if (w_doWrite) begin
      r_bank[r_addr] <= r_wdata;
    end
  end

  // Read data, write pulse and the sticky read-only error flag, all updated
  // on the EXEC edge. rdata is left untouched by writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata   <= '0;
      r_wrPulse <= 1'b0;
      r_roErr   <= 1'b0;
    end else begin
      r_wrPulse <= w_doWrite;
      if (w_doRead) begin
        r_rdata <= (r_addr == RO_A) ? status_i : r_bank[r_addr];
      end
      if (w_roWrite) begin
        r_roErr <= 1'b1;
      end else if (w_doWrite && (r_addr == CTRL_A) && r_wdata[ERR_CLR_BIT]) begin
        r_roErr <= 1'b0;
      end
    end
  end

  assign ack_o      = r_ack;
  assign rdata_o    = r_rdata;
  assign busy_o     = (r_state != ST_IDLE);
  assign ctrl_o     = r_bank[CTRL_A];
  assign wr_pulse_o = r_wrPulse;
  assign ro_err_o   = r_roErr;

endmodule

// File: doc/host_reg_responder.md
# host_reg_responder

Responder end of the host-pin register handshake. An external host, the bench or the board MCU, drives a 4-phase req/ack transaction on the tile pins. This block synchronises the request, executes a single register write or read against a 16×8 register bank, and returns ack plus read data. It sits directly behind the `tt_um_gmejiamtz` top-level pin mapping and feeds control registers into the core.

## Interface
Parameters:
- `DATA_W`, 8: register and data-bus width
- `ADDR_W`, 4: address width; bank holds 2^ADDR_W registers
- `SYNC_STAGES`, 2: flops in the `req_i` synchroniser (≥2)
- `RO_ADDR`, 15: read-only address, returns `status_i`

Ports:
- `clk` in 1: single clock; all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `req_i` in 1: host request level, asynchronous to `clk`
- `we_i` in 1: 1 = write, 0 = read; host-stable while `req_i`=1
- `addr_i` in ADDR_W: register address; host-stable while `req_i`=1
- `wdata_i` in DATA_W: write data; host-stable while `req_i`=1
- `ack_o` out 1: registered acknowledge
- `rdata_o` out DATA_W: read data; valid while `ack_o`=1 on a read
- `busy_o` out 1: FSM not in IDLE
- `ctrl_o` out DATA_W: continuous copy of register 0 to the core
- `status_i` in DATA_W: core status, read at `RO_ADDR`
- `wr_pulse_o` out 1: one-cycle pulse on each accepted write
- `ro_err_o` out 1: sticky flag, set on a write to `RO_ADDR`

## Operation
- `req_i` passes through SYNC_STAGES flops, giving `req_s`. `we_i`, `addr_i` and `wdata_i` are not synchronised; they are captured only in IDLE when `req_s`=1.
- FSM states:
  - WAIT_REL: reset state, `ack_o`=0. Goes to IDLE when `req_s`=0. This blocks replay of a request the host is still holding across reset.
  - IDLE: on `req_s`=1, capture `we`, `addr` and `wdata`, then go to EXEC.
  - EXEC: perform the access, then go to ACK.
    - Write to addr≠RO_ADDR: update the register and pulse `wr_pulse_o`.
    - Write to RO_ADDR: bank unchanged, set `ro_err_o`, no `wr_pulse_o`.
    - Read: load `rdata_o` from the bank, or from `status_i` at RO_ADDR.
  - ACK: `ack_o`=1. Stays while `req_s`=1; on `req_s`=0 goes to IDLE and `ack_o` clears.
- `ro_err_o` clears only on a write to register 0 with bit 7 = 1. Register 0 still takes the written value.
- `rdata_o` holds its last value outside ACK. On a write, `rdata_o` keeps its previous value.
- Reset values:
  - all bank registers 0x00
  - `ack_o`=0, `rdata_o`=0x00, `ctrl_o`=0x00
  - `wr_pulse_o`=0, `ro_err_o`=0, `busy_o`=1 (WAIT_REL)
  - synchroniser flops 0
- Reset mid-transaction aborts it. `ack_o` drops the cycle after reset; a write already executed in EXEC stays lost, since the bank is cleared.

## Timing
- With SYNC_STAGES=2 and `req_i` rising before edge E1:
  - `req_s`=1 after E2
  - IDLE→EXEC at E3
  - EXEC→ACK at E4
  - `ack_o`=1 after E4, so latency is 4 cycles
- Write-to-`ctrl_o` latency: `ctrl_o` updates at the EXEC edge (E4); `wr_pulse_o` is high for exactly the E4–E5 cycle.
- Release: `req_i` falls before edge F1, `req_s`=0 after F2, and `ack_o`=0 after F3.
- Minimum full transaction is 4 + 3 = 7 cycles plus host reaction time.
- A glitch on `req_i` shorter than one cycle may or may not start a transaction. Once started, a transaction always completes the full 4-phase handshake.
- `status_i` is sampled at the EXEC edge.

## Structure
- Package `host_reg_pkg` holds:
  - FSM state enum (WAIT_REL, IDLE, EXEC, ACK)
  - `DATA_W` and `ADDR_W` defaults
  - `RO_ADDR`
  - `CTRL_ADDR`=0 and `ERR_CLR_BIT`=7
- Sub-module `sync_ff`: parameterised N-stage level synchroniser with synchronous reset. It is reused for other asynchronous pins.

## Test plan
- Reset with `req_i` held high for 10 cycles, then deasserted → `busy_o`=1 and no `ack_o` until `req_i` low, then `busy_o`=0. Register 0 stays 0x00.
- Write addr 3 = 0xA5, then read addr 3 → `ack_o` rises exactly 4 cycles after `req_i` and `rdata_o`=0xA5. One `wr_pulse_o` is seen, on the write only.
- Write addr 0 = 0x3C → `ctrl_o`=0x3C from the EXEC edge onward. Release → `ack_o` low 3 cycles after `req_i` falls.
- Set `status_i`=0x5E and read addr 15 → `rdata_o`=0x5E. Then write addr 15 = 0xFF → `ro_err_o`=1, no `wr_pulse_o`, and re-reading addr 15 still gives 0x5E.
- With `ro_err_o`=1, write addr 0 = 0x80 → `ro_err_o`=0 and `ctrl_o`=0x80.
- Assert `rst` for 1 cycle while in ACK → `ack_o`=0 next cycle, all registers 0x00, FSM in WAIT_REL. No new transaction starts until `req_i` has gone low.
